// File: rtl/ysyx_25030093_lsu_bus_if.sv
`default_nettype none
// ============================================================================
// ysyx_25030093_lsu_bus_if : EXU/WBU handshake and memory bus bundle for the LSU.
// Revision: 1.0
// ============================================================================
interface ysyx_25030093_lsu_bus_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] rd_data;
  logic [DATA_W-1:0] rs2_data;
  logic [3:0]        LSU_single;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] LSU_data;
  logic              out_err;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_req_wen;
  logic [DATA_W-1:0] mem_req_wdata;
  logic [3:0]        mem_req_wstrb;
  logic              mem_rsp_valid;
  logic              mem_rsp_ready;
  logic [DATA_W-1:0] mem_rsp_rdata;
  logic              mem_rsp_err;

  // LSU side
  modport master (
    input  in_valid, rd_data, rs2_data, LSU_single, out_ready,
           mem_req_ready, mem_rsp_valid, mem_rsp_rdata, mem_rsp_err,
    output in_ready, out_valid, LSU_data, out_err,
           mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata,
           mem_req_wstrb, mem_rsp_ready
  );

  // EXU / WBU / memory side
  modport slave (
    output in_valid, rd_data, rs2_data, LSU_single, out_ready,
           mem_req_ready, mem_rsp_valid, mem_rsp_rdata, mem_rsp_err,
    input  in_ready, out_valid, LSU_data, out_err,
           mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata,
           mem_req_wstrb, mem_rsp_ready
  );
endinterface
`default_nettype wire

// File: rtl/ysyx_25030093_lsu_bus.sv
`default_nettype none
// ============================================================================
// ysyx_25030093_lsu_bus : single-outstanding load/store unit with lane formatting
// and error reporting; define LSU_TIMEOUT_EN to add the REQ/RSP watchdog.
// Revision: 1.0
// ============================================================================
module ysyx_25030093_lsu_bus #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input wire clk,
  input wire rst_n,
  ysyx_25030093_lsu_bus_if.master bus
);

  localparam logic [3:0] OP_NONE = 4'd0;
  localparam logic [3:0] OP_LB   = 4'd1;
  localparam logic [3:0] OP_LH   = 4'd2;
  localparam logic [3:0] OP_LW   = 4'd3;
  localparam logic [3:0] OP_LBU  = 4'd4;
  localparam logic [3:0] OP_LHU  = 4'd5;
  localparam logic [3:0] OP_SB   = 4'd6;
  localparam logic [3:0] OP_SH   = 4'd7;
  localparam logic [3:0] OP_SW   = 4'd8;

  if (DATA_W != 32) begin : g_bad_data_w
    $error("ysyx_25030093_lsu_bus: DATA_W must be 32");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("ysyx_25030093_lsu_bus: TIMEOUT must be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RSP  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e            state_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] data_q;
  logic              err_q;
  logic              req_valid_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic              req_wen_q;
  logic [DATA_W-1:0] req_wdata_q;
  logic [3:0]        req_wstrb_q;
  logic              rsp_ready_q;
  logic [3:0]        op_q;
  logic [1:0]        addr_lo_q;

  // Decode of the op currently offered by the EXU
  logic              legal_d;
  logic              misal_d;
  logic              store_d;
  logic [3:0]        wstrb_d;
  logic [DATA_W-1:0] wdata_d;
  logic [1:0]        a_lo;

  assign a_lo = bus.rd_data[1:0];

  always_comb begin
    legal_d = 1'b1;
    misal_d = 1'b0;
    store_d = 1'b0;
    wstrb_d = 4'b0000;
    wdata_d = '0;
    case (bus.LSU_single)
      OP_LB, OP_LBU: ;
      OP_LH, OP_LHU: misal_d = a_lo[0];
      OP_LW:         misal_d = (a_lo != 2'b00);
      OP_SB: begin
        store_d = 1'b1;
        wstrb_d = 4'b0001 << a_lo;
        wdata_d = {4{bus.rs2_data[7:0]}};
      end
      OP_SH: begin
        store_d = 1'b1;
        misal_d = a_lo[0];
        wstrb_d = 4'b0011 << a_lo;
        wdata_d = {2{bus.rs2_data[15:0]}};
      end
      OP_SW: begin
        store_d = 1'b1;
        misal_d = (a_lo != 2'b00);
        wstrb_d = 4'b1111;
        wdata_d = bus.rs2_data;
      end
      default: legal_d = 1'b0;
    endcase
  end

  // Load result formatting from the latched op and byte offset
  logic [DATA_W-1:0] shifted_d;
  logic [DATA_W-1:0] load_data_d;

  assign shifted_d = bus.mem_rsp_rdata >> {addr_lo_q, 3'b000};

  always_comb begin
    load_data_d = '0;
    case (op_q)
      OP_LB:   load_data_d = {{(DATA_W-8){shifted_d[7]}}, shifted_d[7:0]};
      OP_LBU:  load_data_d = {{(DATA_W-8){1'b0}}, shifted_d[7:0]};
      OP_LH:   load_data_d = {{(DATA_W-16){shifted_d[15]}}, shifted_d[15:0]};
      OP_LHU:  load_data_d = {{(DATA_W-16){1'b0}}, shifted_d[15:0]};
      OP_LW:   load_data_d = bus.mem_rsp_rdata;
      default: load_data_d = '0;
    endcase
  end

  logic wd_expire_d;

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] wd_cnt_q;
  logic [CNT_W-1:0] wd_cnt_inc;
  logic             wd_run;

  assign wd_cnt_inc  = wd_cnt_q + CNT_W'(1);
  assign wd_expire_d = wd_run && (wd_cnt_inc == CNT_LIM);
  // Counts only while a handshake is pending, so every REQ/RSP entry starts from zero
  assign wd_run = ((state_q == S_REQ) && !bus.mem_req_ready) ||
                  ((state_q == S_RSP) && !bus.mem_rsp_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_run ? wd_cnt_inc : '0;
    end
  end
`else
  assign wd_expire_d = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      data_q      <= '0;
      err_q       <= 1'b0;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      req_wen_q   <= 1'b0;
      req_wdata_q <= '0;
      req_wstrb_q <= 4'b0000;
      rsp_ready_q <= 1'b0;
      op_q        <= OP_NONE;
      addr_lo_q   <= 2'b00;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            in_ready_q <= 1'b0;
            op_q       <= bus.LSU_single;
            addr_lo_q  <= a_lo;
            if (bus.LSU_single == OP_NONE) begin
              data_q      <= DATA_W'(bus.rd_data);
              err_q       <= 1'b0;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end else if (!legal_d || misal_d) begin
              data_q      <= '0;
              err_q       <= 1'b1;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              req_valid_q <= 1'b1;
              req_addr_q  <= {bus.rd_data[ADDR_W-1:2], 2'b00};
              req_wen_q   <= store_d;
              req_wdata_q <= wdata_d;
              req_wstrb_q <= wstrb_d;
              state_q     <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (bus.mem_req_ready) begin
            req_valid_q <= 1'b0;
            rsp_ready_q <= 1'b1;
            state_q     <= S_RSP;
          end else if (wd_expire_d) begin
            req_valid_q <= 1'b0;
            data_q      <= '0;
            err_q       <= 1'b1;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_RSP: begin
          if (bus.mem_rsp_valid) begin
            rsp_ready_q <= 1'b0;
            data_q      <= (bus.mem_rsp_err || req_wen_q) ? '0 : load_data_d;
            err_q       <= bus.mem_rsp_err;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else if (wd_expire_d) begin
            // Dropping rsp_ready here means a late response is never acknowledged
            rsp_ready_q <= 1'b0;
            data_q      <= '0;
            err_q       <= 1'b1;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            data_q      <= '0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.LSU_data      = data_q;
  assign bus.out_err       = err_q;
  assign bus.mem_req_valid = req_valid_q;
  assign bus.mem_req_addr  = req_addr_q;
  assign bus.mem_req_wen   = req_wen_q;
  assign bus.mem_req_wdata = req_wdata_q;
  assign bus.mem_req_wstrb = req_wstrb_q;
  assign bus.mem_rsp_ready = rsp_ready_q;

endmodule
`default_nettype wire
